// File: rtl/card_bus_pkg.sv
// Shared card-bus constants and FSM state type, used by both the initiator and
// the GBARam responder so the two sides agree on bus timing.
package card_bus_pkg;

  localparam int CB_ADDR_W      = 16;
  localparam int CB_DATA_W      = 8;
  localparam int CB_HOLD_CYCLES = 5;
  localparam int CB_IDLE_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } state_t;

endpackage

// File: rtl/card_bus_initiator.sv
// Host-side card-bus master: one valid/ready byte request becomes one fixed-window
// bus access followed by a forced idle gap; read data returns on a response pulse.
module card_bus_initiator
  import card_bus_pkg::*;
#(
  parameter int ADDR_W      = CB_ADDR_W,
  parameter int DATA_W      = CB_DATA_W,
  parameter int HOLD_CYCLES = CB_HOLD_CYCLES,
  parameter int IDLE_CYCLES = CB_IDLE_CYCLES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] io_card_bus_addr,
  output logic [DATA_W-1:0] io_card_bus_mosi,
  input  logic [DATA_W-1:0] io_card_bus_miso,
  output logic              io_card_bus_write,
  output logic              busy
);

  localparam int CNT_MAX = (HOLD_CYCLES > IDLE_CYCLES) ? HOLD_CYCLES : IDLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);

  if (HOLD_CYCLES < 2 || IDLE_CYCLES < 1) begin : g_param_check
    $error("card_bus_initiator: HOLD_CYCLES must be >= 2 and IDLE_CYCLES >= 1");
  end

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   mosi_d;
  logic                write_d;
  logic                rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_d;
  logic                req_ready_d;

  // The bus registers double as the latched request, so nothing on req_* is
  // looked at again once the access has been accepted.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    addr_d      = io_card_bus_addr;
    mosi_d      = io_card_bus_mosi;
    write_d     = io_card_bus_write;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;

    unique case (state)
      IDLE: begin
        if (req_valid) begin
          state_d = ACCESS;
          cnt_d   = '0;
          addr_d  = req_addr;
          mosi_d  = req_write ? req_wdata : '0;
          write_d = req_write;
        end
      end
      ACCESS: begin
        if (cnt == HOLD_LAST) begin
          rsp_rdata_d = io_card_bus_write ? '0 : io_card_bus_miso;
          rsp_valid_d = 1'b1;
          addr_d      = '0;
          mosi_d      = '0;
          write_d     = 1'b0;
          state_d     = RECOVER;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      RECOVER: begin
        if (cnt == IDLE_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Registered ready: low throughout reset, high from the first edge after release.
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      cnt               <= '0;
      io_card_bus_addr  <= '0;
      io_card_bus_mosi  <= '0;
      io_card_bus_write <= 1'b0;
      rsp_valid         <= 1'b0;
      rsp_rdata         <= '0;
      req_ready         <= 1'b0;
    end else begin
      state             <= state_d;
      cnt               <= cnt_d;
      io_card_bus_addr  <= addr_d;
      io_card_bus_mosi  <= mosi_d;
      io_card_bus_write <= write_d;
      rsp_valid         <= rsp_valid_d;
      rsp_rdata         <= rsp_rdata_d;
      req_ready         <= req_ready_d;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_card_bus_initiator.sv
// Bench for card_bus_initiator: a default-timing instance against a byte-array
// responder model, plus a short-timing instance for the fast parameter set.
module tb_card_bus_initiator;

  localparam int H = 5;
  localparam int I = 2;
  localparam int P = 1 + H + I;

  logic        clock;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [15:0] bus_addr;
  logic [7:0]  bus_mosi, bus_miso;
  logic        bus_write, busy;

  logic        v_s, rdy_s, w_s, rv_s, bw_s, busy_s;
  logic [15:0] a_s, ba_s;
  logic [7:0]  d_s, rd_s, bm_s, bmi_s;

  logic [7:0]  mem     [0:65535];
  logic [7:0]  mem2    [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [7:0]  sb[$];
  logic [7:0]  sb2[$];

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_rsp2 = 0;
  int unsigned cyc = 0;
  int unsigned last_acc = 0;

  card_bus_initiator #(
    .ADDR_W(16), .DATA_W(8), .HOLD_CYCLES(H), .IDLE_CYCLES(I)
  ) u_dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .io_card_bus_addr(bus_addr), .io_card_bus_mosi(bus_mosi),
    .io_card_bus_miso(bus_miso), .io_card_bus_write(bus_write),
    .busy(busy)
  );

  card_bus_initiator #(
    .ADDR_W(16), .DATA_W(8), .HOLD_CYCLES(2), .IDLE_CYCLES(1)
  ) u_dut_fast (
    .clock(clock), .reset(reset),
    .req_valid(v_s), .req_ready(rdy_s), .req_write(w_s),
    .req_addr(a_s), .req_wdata(d_s),
    .rsp_valid(rv_s), .rsp_rdata(rd_s),
    .io_card_bus_addr(ba_s), .io_card_bus_mosi(bm_s),
    .io_card_bus_miso(bmi_s), .io_card_bus_write(bw_s),
    .busy(busy_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Responder models: combinational miso, write captured on the clock edge.
  assign bus_miso = mem[bus_addr];
  assign bmi_s    = mem2[ba_s];
  always @(posedge clock) if (bus_write) mem[bus_addr] <= bus_mosi;
  always @(posedge clock) if (bw_s) mem2[ba_s] <= bm_s;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (rsp_valid) begin
      if (sb.size() == 0) check("rsp_unexpected", 1, 0);
      else check("rsp_rdata", {24'h0, rsp_rdata}, {24'h0, sb.pop_front()});
    end
    if (rv_s) begin
      n_rsp2++;
      if (sb2.size() == 0) check("fast_rsp_unexpected", 1, 0);
      else check("fast_rsp_rdata", {24'h0, rd_s}, {24'h0, sb2.pop_front()});
    end
  end

  // Called on a negedge; returns on the negedge of the first IDLE cycle after the access.
  task automatic access(input logic w, input logic [15:0] a, input logic [7:0] d,
                        input bit keep, input bit cont);
    int unsigned waited;
    logic [7:0]  exp_mosi;
    waited    = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && waited < 40) begin
      @(negedge clock);
      waited++;
    end
    if (!req_ready) begin
      check("accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    if (cont) check("accept_period", cyc - last_acc, P);
    last_acc = cyc;
    @(posedge clock);
    sb.push_back(w ? 8'h00 : ref_mem[a]);
    if (w) ref_mem[a] = d;
    exp_mosi = w ? d : 8'h00;
    for (int k = 0; k < H; k++) begin
      @(negedge clock);
      if (keep) begin
        req_write = ~w;
        req_addr  = ~a;
        req_wdata = ~d;
      end else begin
        req_valid = 1'b0;
      end
      check("access_bus", {bus_addr, bus_mosi, bus_write, req_ready, rsp_valid, busy},
            {a, exp_mosi, w, 1'b0, 1'b0, 1'b1});
    end
    @(negedge clock);
    check("rsp_edge", {bus_addr, bus_mosi, bus_write, req_ready, rsp_valid, busy},
          {16'h0, 8'h0, 1'b0, 1'b0, 1'b1, 1'b1});
    for (int k = 1; k < I; k++) begin
      @(negedge clock);
      check("recover_bus", {bus_addr, bus_mosi, bus_write, req_ready, rsp_valid, busy},
            {16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b1});
    end
    @(negedge clock);
    check("idle_ready", {bus_addr, bus_mosi, bus_write, req_ready, rsp_valid, busy},
          {16'h0, 8'h0, 1'b0, 1'b1, 1'b0, 1'b0});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned waited;
    int unsigned t0;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 8'h00;
      mem2[i]    = 8'h00;
      ref_mem[i] = 8'h00;
    end
    reset     = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 16'h0001;
    req_wdata = 8'h77;
    v_s = 1'b0; w_s = 1'b0; a_s = 16'h0; d_s = 8'h0;

    repeat (3) begin
      @(negedge clock);
      check("reset_outputs",
            {bus_addr, bus_mosi, bus_write, req_ready, rsp_valid, rsp_rdata, busy}, 32'h0);
    end
    req_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clock);
    check("reset_release_ready", {31'h0, req_ready}, 1);

    access(1'b1, 16'h0001, 8'h42, 1'b0, 1'b0);
    access(1'b1, 16'h0002, 8'hAA, 1'b0, 1'b1);
    access(1'b1, 16'h0003, 8'h55, 1'b0, 1'b1);
    check("mem_0001", {24'h0, mem[1]}, 32'h42);
    check("mem_0002", {24'h0, mem[2]}, 32'hAA);
    check("mem_0003", {24'h0, mem[3]}, 32'h55);

    access(1'b0, 16'h0001, 8'h00, 1'b0, 1'b1);
    access(1'b0, 16'h0003, 8'h00, 1'b0, 1'b1);
    access(1'b0, 16'h0002, 8'h00, 1'b0, 1'b1);

    // Valid held high with the payload scrambled mid-access.
    access(1'b1, 16'h0010, 8'h11, 1'b1, 1'b1);
    access(1'b1, 16'h0011, 8'h22, 1'b1, 1'b1);
    access(1'b0, 16'h0010, 8'h00, 1'b1, 1'b1);
    access(1'b0, 16'h0011, 8'h00, 1'b1, 1'b1);
    req_valid = 1'b0;

    // Reset on the third ACCESS cycle of a write.
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0004; req_wdata = 8'h99;
    waited = 0;
    while (!req_ready && waited < 40) begin @(negedge clock); waited++; end
    check("mr_ready_before", {31'h0, req_ready}, 1);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    check("mr_bus_write", {bus_addr, bus_mosi, bus_write}, {16'h0004, 8'h99, 1'b1});
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    #1 check("mr_async_clear",
             {bus_addr, bus_mosi, bus_write, req_ready, rsp_valid, rsp_rdata, busy}, 32'h0);
    repeat (H + 2) begin
      @(negedge clock);
      check("mr_no_rsp", {29'h0, rsp_valid, req_ready, busy}, 0);
    end
    reset = 1'b1;
    @(negedge clock);
    check("mr_release_ready", {31'h0, req_ready}, 1);
    access(1'b0, 16'h0001, 8'h00, 1'b0, 1'b0);

    // Fast-timing instance: HOLD=2, IDLE=1 gives a 4-clock period.
    v_s = 1'b1; w_s = 1'b1; a_s = 16'h0002; d_s = 8'hAA;
    waited = 0;
    while (!rdy_s && waited < 20) begin @(negedge clock); waited++; end
    t0 = cyc;
    @(posedge clock);
    sb2.push_back(8'h00);
    @(negedge clock);
    w_s = 1'b0; d_s = 8'h00;
    waited = 0;
    while (!rdy_s && waited < 20) begin @(negedge clock); waited++; end
    check("fast_period", cyc - t0, 4);
    @(posedge clock);
    sb2.push_back(8'hAA);
    @(negedge clock);
    v_s = 1'b0;
    repeat (6) @(negedge clock);
    check("fast_rsp_count", n_rsp2, 2);
    check("fast_idle", {7'h0, ba_s, bm_s, bw_s, busy_s}, 32'h0);
    check("fast_mem_0002", {24'h0, mem2[2]}, 32'hAA);

    repeat (4) @(negedge clock);
    check("sb_drained", sb.size(), 0);
    check("fast_sb_drained", sb2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
